// File: rtl/constants.sv
// Shared constants for the synth audio path and the I2S transmitter defaults.
package constants;

    localparam int SYNTH_WIDTH    = 24;
    localparam int I2S_SLOT_WIDTH = 24;
    localparam int I2S_SCLK_DIV   = 16;
    localparam int I2S_FIFO_DEPTH = 4;

    typedef enum {FMT_I2S, FMT_LEFT_JUSTIFIED} i2s_format_t;

    typedef enum logic {ST_IDLE, ST_STREAM} i2s_tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; pushes while full and pops while empty are ignored.
module sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_stream_tx.sv
// Stereo I2S / left-justified transmitter: pair FIFO, SCLK/LRCK counters, MSB-first serialiser.
//
// state     | meaning
// ST_IDLE   | clocks run, frames silent, underrun not reported
// ST_STREAM | frames loaded from FIFO; empty FIFO at a frame start pulses underrun
module i2s_stream_tx
    import constants::*;
#(
    parameter int          SAMPLE_WIDTH = SYNTH_WIDTH,
    parameter int          SLOT_WIDTH   = I2S_SLOT_WIDTH,
    parameter int          SCLK_DIV     = I2S_SCLK_DIV,
    parameter int          FIFO_DEPTH   = I2S_FIFO_DEPTH,
    parameter i2s_format_t FORMAT       = FMT_I2S
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    output logic                    mclk_out,
    output logic                    sclk_out,
    output logic                    lrck_out,
    output logic                    sdin_out,
    output logic                    underrun_out
);

    localparam int DW    = $clog2(SCLK_DIV);
    localparam int BW    = $clog2(2 * SLOT_WIDTH);
    localparam int FW    = 2 * SAMPLE_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int DELAY = (FORMAT == FMT_I2S) ? 1 : 0;
    localparam bit SPILL = (DELAY == 1) && (SAMPLE_WIDTH == SLOT_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);

    i2s_tx_state_t r_state;
    i2s_tx_state_t w_state_nxt;

    logic [DW-1:0]           r_div_cnt;
    logic [BW-1:0]           r_bit_cnt;
    logic [FW-1:0]           r_frame;
    logic                    r_sclk;
    logic                    r_lrck;
    logic                    r_sdin;
    logic                    r_underrun;

    logic                    w_tick;
    logic                    w_boundary;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_underrun;
    logic [BW-1:0]           w_bit_nxt;
    logic [FW-1:0]           w_frame_nxt;
    logic                    w_right;
    logic                    w_sdin_nxt;
    logic [SAMPLE_WIDTH-1:0] w_smp;
    logic [SAMPLE_WIDTH-1:0] w_shift;
    int                      w_pos;
    int                      w_d;

    logic [FW-1:0]           w_fifo_dout;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [CW-1:0]           w_fifo_count;

    assign mclk_out     = clk_in;
    assign sclk_out     = r_sclk;
    assign lrck_out     = r_lrck;
    assign sdin_out     = r_sdin;
    assign underrun_out = r_underrun;

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_tick && (r_bit_cnt == BIT_LAST);
    assign ready_out  = !rst_in && !w_fifo_full;
    assign w_push     = valid_in && ready_out;
    assign w_pop      = w_boundary && !w_fifo_empty;

    sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_push),
        .i_data  ({left_in, right_in}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_underrun  = 1'b0;
        if (w_boundary) begin
            if (w_fifo_count != '0) begin
                w_state_nxt = ST_STREAM;
            end else if (r_state == ST_STREAM) begin
                w_underrun = 1'b1;
            end
        end
    end

    // Everything below describes the bit that goes out after the next tick.
    always_comb begin
        w_frame_nxt = r_frame;
        if (w_boundary) begin
            w_frame_nxt = w_pop ? w_fifo_dout : '0;
        end
        w_bit_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
    end

    always_comb begin
        w_pos      = int'(w_bit_nxt);
        w_right    = (w_pos >= SLOT_WIDTH);
        if (w_right) begin
            w_pos = w_pos - SLOT_WIDTH;
        end
        w_d        = w_pos - DELAY;
        w_smp      = w_right ? w_frame_nxt[SAMPLE_WIDTH-1:0] : w_frame_nxt[FW-1:SAMPLE_WIDTH];
        w_shift    = '0;
        w_sdin_nxt = 1'b0;
        if (w_d >= 0 && w_d < SAMPLE_WIDTH) begin
            w_shift    = w_smp >> (SAMPLE_WIDTH - 1 - w_d);
            w_sdin_nxt = w_shift[0];
        end else if (SPILL && w_pos == 0) begin
            // Delayed LSB of the half-frame just finished: right LSB of the old frame, or left LSB of this one.
            w_sdin_nxt = w_right ? r_frame[SAMPLE_WIDTH] : r_frame[0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_frame    <= '0;
            r_sclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_sdin     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_div_cnt  <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_underrun <= w_underrun;
            if (r_div_cnt == DIV_HALF) begin
                r_sclk <= 1'b1;
            end
            if (w_tick) begin
                r_sclk    <= 1'b0;
                r_bit_cnt <= w_bit_nxt;
                r_frame   <= w_frame_nxt;
                r_lrck    <= w_right;
                r_sdin    <= w_sdin_nxt;
            end
        end
    end

endmodule

// File: doc/i2s_stream_tx.md
# i2s_stream_tx

Parametrised I2S / left-justified stereo transmitter for the Pmod I2S2 DAC path. Accepts left/right sample pairs from the synth on a valid/ready handshake, buffers them in a small FIFO, and serialises them MSB-first. MCLK, SCLK and LRCK are all generated in the single `clk_in` domain; no logic is clocked on a derived clock. Replaces the fixed 24-bit mono-duplicated transmitter with configurable widths, ratios, format, backpressure and underrun reporting.

## Interface
Parameters:
- `SAMPLE_WIDTH`, default `SYNTH_WIDTH` (24): bits per channel sample.
- `SLOT_WIDTH`, default 24: SCLK periods per channel half-frame; must be ≥ `SAMPLE_WIDTH`.
- `SCLK_DIV`, default 16: `clk_in` cycles per SCLK period; even, ≥ 4.
- `FIFO_DEPTH`, default 4: stereo pairs buffered; power of 2, ≥ 2.
- `FORMAT`, default `FMT_I2S`: `FMT_I2S` (data delayed 1 SCLK after LRCK edge) or `FMT_LEFT_JUSTIFIED` (no delay).

Ports:
- `clk_in` in 1: system clock (~36.864 MHz), also MCLK.
- `rst_in` in 1: reset. One clock; reset is synchronous and active-high.
- `valid_in` in 1: sample pair valid.
- `ready_out` out 1: FIFO can accept a pair.
- `left_in` in `SAMPLE_WIDTH`: left sample, two's complement.
- `right_in` in `SAMPLE_WIDTH`: right sample, two's complement.
- `mclk_out` out 1: equals `clk_in`.
- `sclk_out` out 1: bit clock.
- `lrck_out` out 1: 0 = left half, 1 = right half.
- `sdin_out` out 1: serial data to DAC.
- `underrun_out` out 1: 1-cycle pulse when a frame starts with FIFO empty while streaming.

## Operation
- Divider `div_cnt` 0..`SCLK_DIV`-1, free-running. Tick = cycle with `div_cnt == SCLK_DIV-1`.
- On edge where `div_cnt == SCLK_DIV/2-1`: `sclk_out` ← 1. On tick edge: `sclk_out` ← 0, `bit_cnt` advances, `lrck_out`/`sdin_out` update for the new bit. Data changes on SCLK falling, stable at rising.
- `bit_cnt` 0..2·`SLOT_WIDTH`-1, wraps. `lrck_out` = (`bit_cnt` ≥ `SLOT_WIDTH`). Slot position p = `bit_cnt` mod `SLOT_WIDTH`.
- DELAY = 1 (I2S) or 0 (LJ). d = p − DELAY. If 0 ≤ d < `SAMPLE_WIDTH`: `sdin_out` = sample[`SAMPLE_WIDTH`-1-d] of current channel; else 0 (zero padding).
- I2S spill: when DELAY=1 and `SAMPLE_WIDTH == SLOT_WIDTH`, p=0 carries LSB of the previous half-frame's sample (right LSB at left p=0, left LSB at right p=0); otherwise p=0 is 0.
- Frame boundary = tick where `bit_cnt` wraps to 0. At boundary: if FIFO non-empty, pop head into frame register (used from p=0 of this frame); if empty, frame register ← 0.
- States: IDLE (after reset; clocks run, `sdin_out` 0, no underrun reporting) → STREAM at first boundary with FIFO non-empty. STREAM + empty at boundary → `underrun_out` pulse, zero frame, stay STREAM. Only reset returns to IDLE.
- FIFO: push on `valid_in && ready_out`. `ready_out` = !full from registered count, 0 while `rst_in`. Pop and push same cycle: count unchanged. Push and pop same cycle when full: no push (ready already 0). Push into empty FIFO on a boundary cycle is not visible to that boundary's pop.

## Timing
- Reset values (cycle after `rst_in` high): `div_cnt` 0, `bit_cnt` 0, `sclk_out` 0, `lrck_out` 0, `sdin_out` 0, `underrun_out` 0, FIFO empty, state IDLE, spill bits 0. Reset mid-frame aborts immediately; flushes FIFO.
- Frame rate = f_clk / (`SCLK_DIV` · 2 · `SLOT_WIDTH`); defaults give 48 kHz.
- Latency: pair pushed at edge E appears at the next boundary after E; LJ MSB on `sdin_out` at that boundary edge, I2S MSB one SCLK (`SCLK_DIV` cycles) later.
- `underrun_out` asserted exactly the cycle after the boundary edge, one cycle wide.

## Structure
- Package `constants`: add `typedef enum {FMT_I2S, FMT_LEFT_JUSTIFIED} i2s_format_t;` and defaults `I2S_SLOT_WIDTH`, `I2S_SCLK_DIV`, `I2S_FIFO_DEPTH`.
- Sub-module `sample_fifo` (synchronous, params WIDTH/DEPTH, push/pop/full/empty/count); instantiated with WIDTH = 2·`SAMPLE_WIDTH`.
- Top holds divider, bit counter, state, frame register, output mux.

## Test plan
- Defaults, IDLE, push L=24'hA5A5A5 R=24'h000001 → next frame: LRCK low 24 SCLK; left p=0 is 0, p=1..23 = bits 23..1 of A5A5A5; right p=0 = L LSB (1), p=1..23 = 0x000001 bits 23..1; next left p=0 = 1.
- `FORMAT=FMT_LEFT_JUSTIFIED`, `SAMPLE_WIDTH=16`, `SLOT_WIDTH=32`, L=16'h8001 → left p=0..15 = 1000…0001, p=16..31 = 0; SCLK period 16 cycles, high 8.
- Push 4 pairs with no frames elapsed → `ready_out` 0 after 4th; 5th `valid_in` held, accepted the cycle after the next boundary pop.
- Stream 2 pairs then stop → third boundary: `underrun_out` single-cycle pulse, all-zero frame; none while IDLE before first push.
- Assert `rst_in` mid-right-half with 3 pairs queued → next cycle all outputs 0, `ready_out` 1 after release, no stale data transmitted.
- Check `lrck_out` period = 768 cycles and toggles only on tick edges (defaults).
